// File: rtl/vc_scheduler_if.sv
// FIFO-side handshake bundle of the VC scheduler: two VC source FIFOs in,
// two destination FIFOs out.
interface vc_scheduler_if #(
    parameter int DATA_SIZE = 6
);
    logic                 vc0_empty;
    logic                 vc1_empty;
    logic [DATA_SIZE-1:0] vc0_data;
    logic [DATA_SIZE-1:0] vc1_data;
    logic                 d0_almost_full;
    logic                 d1_almost_full;
    logic                 vc0_pop;
    logic                 vc1_pop;
    logic                 d0_push;
    logic                 d1_push;
    logic [DATA_SIZE-1:0] d_data;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data
    );
endinterface

// File: rtl/vc_scheduler.sv
// Weighted VC0/VC1 -> D0/D1 scheduler: one pop per cycle, registered push one
// cycle later, VC0:VC1 service ratio bounded by VC0_WEIGHT.
module vc_scheduler #(
    parameter int DATA_SIZE  = 6,
    parameter int DEST_BIT   = 4,
    parameter int VC0_WEIGHT = 3,
    parameter int CNT_SIZE   = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enable,
    vc_scheduler_if.master      bus,
    output logic [CNT_SIZE-1:0] vc0_served,
    output logic [CNT_SIZE-1:0] vc1_served,
    output logic                sched_idle
);

    localparam int WCNT_W = (VC0_WEIGHT < 1) ? 1 : $clog2(VC0_WEIGHT + 1);
    localparam logic [WCNT_W-1:0]   WCNT_MAX  = WCNT_W'(VC0_WEIGHT);
    localparam logic [WCNT_W-1:0]   WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0]   WCNT_ZERO = WCNT_W'(0);
    localparam logic [CNT_SIZE-1:0] CNT_ONE   = CNT_SIZE'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [WCNT_W-1:0]     wcnt_r;
    logic [WCNT_W-1:0]     wcnt_nx_s;
    logic                  vc0_elig_s;
    logic                  vc1_elig_s;
    logic                  grant0_s;
    logic                  grant1_s;
    logic [DATA_SIZE-1:0]  sel_data_s;
    logic                  d0_push_r;
    logic                  d1_push_r;
    logic [DATA_SIZE-1:0]  d_data_r;
    logic [CNT_SIZE-1:0]   vc0_served_r;
    logic [CNT_SIZE-1:0]   vc1_served_r;

    // A head word is blocked when the destination it selects is almost full.
    function automatic logic dest_blocked(input logic [DATA_SIZE-1:0] word,
                                          input logic af0, input logic af1);
        if (word[DEST_BIT]) begin
            return af1;
        end else begin
            return af0;
        end
    endfunction

    // Eligibility; reset forces both low so no pop is issued while in reset.
    always_comb begin
        vc0_elig_s = enable & ~reset_L & ~bus.vc0_empty &
                     ~dest_blocked(bus.vc0_data, bus.d0_almost_full, bus.d1_almost_full);
        vc1_elig_s = enable & ~reset_L & ~bus.vc1_empty &
                     ~dest_blocked(bus.vc1_data, bus.d0_almost_full, bus.d1_almost_full);
    end

    // State register: RUN marks a grant in the previous cycle (push now in flight).
    always_ff @(posedge clk) begin
        if (reset_L) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = ST_IDLE;
        if (vc0_elig_s | vc1_elig_s) begin
            state_nx_s = ST_RUN;
        end else begin
            state_nx_s = ST_IDLE;
        end
    end

    // Grant decision and weight-counter update.
    always_comb begin
        grant0_s  = 1'b0;
        grant1_s  = 1'b0;
        wcnt_nx_s = wcnt_r;
        case ({vc1_elig_s, vc0_elig_s})
            2'b11: begin
                if (wcnt_r < WCNT_MAX) begin
                    grant0_s  = 1'b1;
                    wcnt_nx_s = wcnt_r + WCNT_ONE;
                end else begin
                    grant1_s  = 1'b1;
                    wcnt_nx_s = WCNT_ZERO;
                end
            end
            2'b01: begin
                grant0_s = 1'b1;
                if (wcnt_r < WCNT_MAX) begin
                    wcnt_nx_s = wcnt_r + WCNT_ONE;
                end else begin
                    wcnt_nx_s = wcnt_r;
                end
            end
            2'b10: begin
                grant1_s  = 1'b1;
                wcnt_nx_s = WCNT_ZERO;
            end
            default: begin
                wcnt_nx_s = wcnt_r;
            end
        endcase
    end

    // Head word of the granted VC.
    always_comb begin
        sel_data_s = bus.vc0_data;
        if (grant1_s) begin
            sel_data_s = bus.vc1_data;
        end else begin
            sel_data_s = bus.vc0_data;
        end
    end

    // Datapath registers: push strobes, forwarded word, served counters.
    always_ff @(posedge clk) begin
        if (reset_L) begin
            wcnt_r       <= WCNT_ZERO;
            d0_push_r    <= 1'b0;
            d1_push_r    <= 1'b0;
            d_data_r     <= '0;
            vc0_served_r <= '0;
            vc1_served_r <= '0;
        end else begin
            wcnt_r    <= wcnt_nx_s;
            d0_push_r <= (grant0_s | grant1_s) & ~sel_data_s[DEST_BIT];
            d1_push_r <= (grant0_s | grant1_s) &  sel_data_s[DEST_BIT];
            if (grant0_s | grant1_s) begin
                d_data_r <= sel_data_s;
            end else begin
                d_data_r <= d_data_r;
            end
            if (grant0_s) begin
                vc0_served_r <= vc0_served_r + CNT_ONE;
            end else begin
                vc0_served_r <= vc0_served_r;
            end
            if (grant1_s) begin
                vc1_served_r <= vc1_served_r + CNT_ONE;
            end else begin
                vc1_served_r <= vc1_served_r;
            end
        end
    end

    assign bus.vc0_pop = grant0_s;
    assign bus.vc1_pop = grant1_s;
    assign bus.d0_push = d0_push_r;
    assign bus.d1_push = d1_push_r;
    assign bus.d_data  = d_data_r;
    assign vc0_served  = vc0_served_r;
    assign vc1_served  = vc1_served_r;
    // No grant last cycle means no push in flight either.
    assign sched_idle  = (state_r == ST_IDLE);

endmodule

// File: tb/tb_vc_scheduler.sv
// Self-checking bench for vc_scheduler: bench-owned FIFO models, an arbitration
// model and a scoreboard of expected pushes.
module tb_vc_scheduler;

    localparam int DS = 6;
    localparam int DB = 4;
    localparam int W  = 3;
    localparam int CS = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b1;
    logic          en = 1'b0;
    logic [CS-1:0] vc0_served;
    logic [CS-1:0] vc1_served;
    logic          sched_idle;

    vc_scheduler_if #(.DATA_SIZE(DS)) bus_if ();

    vc_scheduler #(
        .DATA_SIZE(DS), .DEST_BIT(DB), .VC0_WEIGHT(W), .CNT_SIZE(CS)
    ) dut (
        .clk(clk), .reset_L(reset_L), .enable(en), .bus(bus_if.master),
        .vc0_served(vc0_served), .vc1_served(vc1_served), .sched_idle(sched_idle)
    );

    always #5 clk = ~clk;

    logic [DS-1:0] vc0_q[$];
    logic [DS-1:0] vc1_q[$];
    logic [DS-1:0] exp_q[$];
    logic          af0_b = 1'b0;
    logic          af1_b = 1'b0;
    logic [CS-1:0] m_s0 = '0;
    logic [CS-1:0] m_s1 = '0;
    int            c0 = 0;
    logic          prev_grant = 1'b0;
    logic [1:0]    last_pops;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic drive_inputs();
        bus_if.vc0_empty      = (vc0_q.size() == 0);
        bus_if.vc1_empty      = (vc1_q.size() == 0);
        bus_if.vc0_data       = (vc0_q.size() == 0) ? 6'h00 : vc0_q[0];
        bus_if.vc1_data       = (vc1_q.size() == 0) ? 6'h00 : vc1_q[0];
        bus_if.d0_almost_full = af0_b;
        bus_if.d1_almost_full = af1_b;
    endtask

    // One clock: check outputs at negedge against the model, advance the model.
    task automatic step();
        logic [DS-1:0] w;
        logic e0, e1, g0, g1;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            if (bus_if.d0_push !== ~w[DB] || bus_if.d1_push !== w[DB] || bus_if.d_data !== w) begin
                $display("FAIL push: d0_push=%b d1_push=%b d_data=%h, required word %h to D%0d",
                         bus_if.d0_push, bus_if.d1_push, bus_if.d_data, w, w[DB]);
            end else n_pass++;
        end else begin
            if ({bus_if.d0_push, bus_if.d1_push} !== 2'b00) begin
                $display("FAIL no_push: d0_push=%b d1_push=%b, required 0 0",
                         bus_if.d0_push, bus_if.d1_push);
            end else n_pass++;
        end
        n_checks++;
        if (sched_idle !== ~prev_grant) begin
            $display("FAIL sched_idle: got %b, required %b", sched_idle, ~prev_grant);
        end else n_pass++;
        n_checks++;
        if (vc0_served !== m_s0 || vc1_served !== m_s1) begin
            $display("FAIL served: got %0d/%0d, required %0d/%0d", vc0_served, vc1_served, m_s0, m_s1);
        end else n_pass++;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset_L && en) begin
            if (vc0_q.size() > 0) e0 = !(vc0_q[0][DB] ? af1_b : af0_b);
            if (vc1_q.size() > 0) e1 = !(vc1_q[0][DB] ? af1_b : af0_b);
        end
        g1 = e1 && (!e0 || c0 >= W);
        g0 = e0 && !g1;
        last_pops = {bus_if.vc1_pop, bus_if.vc0_pop};
        n_checks++;
        if (last_pops !== {g1, g0}) begin
            $display("FAIL pop: vc1_pop,vc0_pop=%b, required %b", last_pops, {g1, g0});
        end else n_pass++;
        if (reset_L) begin
            exp_q.delete();
            m_s0 = '0;
            m_s1 = '0;
            c0 = 0;
            prev_grant = 1'b0;
        end else begin
            if (g0) begin
                exp_q.push_back(vc0_q.pop_front());
                m_s0++;
                if (c0 < W) c0++;
            end
            if (g1) begin
                exp_q.push_back(vc1_q.pop_front());
                m_s1++;
                c0 = 0;
            end
            prev_grant = g0 | g1;
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        vc0_q.delete();
        vc1_q.delete();
        af0_b = 1'b0;
        af1_b = 1'b0;
        drive_inputs();
        reset_L = 1'b1;
        step();
        step();
        reset_L = 1'b0;
    endtask

    task automatic test_reset();
        vc0_q = '{6'h01, 6'h03};
        vc1_q = '{6'h12};
        en = 1'b1;
        drive_inputs();
        reset_L = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus_if.vc0_pop, bus_if.vc1_pop, bus_if.d0_push, bus_if.d1_push} !== 4'b0000 ||
            bus_if.d_data !== 6'h00 || sched_idle !== 1'b1) begin
            $display("FAIL reset_state: pops=%b%b pushes=%b%b d_data=%h idle=%b, required all 0 and idle 1",
                     bus_if.vc0_pop, bus_if.vc1_pop, bus_if.d0_push, bus_if.d1_push, bus_if.d_data, sched_idle);
        end else n_pass++;
        vc0_q.delete();
        vc1_q.delete();
        drive_inputs();
        reset_L = 1'b0;
    endtask

    task automatic test_vc0_stream();
        vc0_q = '{6'h05, 6'h15, 6'h25};
        drive_inputs();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (vc0_served !== 8'd3 || vc1_served !== 8'd0) begin
            $display("FAIL vc0_stream_served: got %0d/%0d, required 3/0", vc0_served, vc1_served);
        end else n_pass++;
        step();
    endtask

    task automatic test_weighting();
        logic [1:0] exp_seq [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vc0_q.push_back(6'(i));
            vc1_q.push_back(6'(6'h20 + i));
        end
        drive_inputs();
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (last_pops !== exp_seq[i]) begin
                $display("FAIL weight_seq[%0d]: pops=%b, required %b", i, last_pops, exp_seq[i]);
            end else n_pass++;
        end
        vc0_q.delete();
        vc1_q.delete();
        drive_inputs();
        step();
        n_checks++;
        if (vc0_served !== 8'd6 || vc1_served !== 8'd2) begin
            $display("FAIL weight_served: got %0d/%0d, required 6/2", vc0_served, vc1_served);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        vc0_q = '{6'h13};
        vc1_q = '{6'h02};
        af1_b = 1'b1;
        drive_inputs();
        step();
        n_checks++;
        if (last_pops !== 2'b10) begin
            $display("FAIL bp_blocked: pops=%b, required 10", last_pops);
        end else n_pass++;
        af1_b = 1'b0;
        drive_inputs();
        step();
        n_checks++;
        if (last_pops !== 2'b01) begin
            $display("FAIL bp_release: pops=%b, required 01", last_pops);
        end else n_pass++;
        step();
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int i = 0; i < 6; i++) vc0_q.push_back(6'(6'h08 + 6'(i * 5)));
        drive_inputs();
        for (int i = 0; i < 3; i++) step();
        en = 1'b0;
        step();
        n_checks++;
        if (last_pops !== 2'b00) begin
            $display("FAIL enable_drop_pop: pops=%b, required 00", last_pops);
        end else n_pass++;
        n_checks++;
        if (sched_idle !== 1'b1) begin
            $display("FAIL enable_drop_idle: got %b, required 1", sched_idle);
        end else n_pass++;
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) vc1_q.push_back(6'(i));
        drive_inputs();
        for (int i = 0; i < 256; i++) step();
        n_checks++;
        if (vc1_served !== 8'd0 || vc0_served !== 8'd0) begin
            $display("FAIL counter_wrap: got %0d/%0d, required 0/0", vc0_served, vc1_served);
        end else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int guard;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (vc0_q.size() < 4 && $urandom_range(0, 3) != 0) vc0_q.push_back(6'($urandom_range(0, 63)));
            if (vc1_q.size() < 4 && $urandom_range(0, 3) != 0) vc1_q.push_back(6'($urandom_range(0, 63)));
            af0_b = ($urandom_range(0, 4) == 0);
            af1_b = ($urandom_range(0, 4) == 0);
            en    = ($urandom_range(0, 9) != 0);
            drive_inputs();
            step();
        end
        en = 1'b1;
        af0_b = 1'b0;
        af1_b = 1'b0;
        drive_inputs();
        guard = 0;
        while ((vc0_q.size() > 0 || vc1_q.size() > 0 || exp_q.size() > 0) && guard < 50) begin
            step();
            guard++;
        end
        n_checks++;
        if (vc0_q.size() + vc1_q.size() + exp_q.size() != 0) begin
            $display("FAIL drain: %0d words left after 50 cycles, required 0",
                     vc0_q.size() + vc1_q.size() + exp_q.size());
        end else n_pass++;
    endtask

    initial begin
        drive_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_vc0_stream();
        test_weighting();
        test_backpressure();
        test_enable_drop();
        test_counter_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_scheduler.md
# vc_scheduler

Weighted scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). Each cycle it selects at most one head word from VC0 or VC1, pops it, and pushes it one cycle later into D0 or D1 according to the word's destination bit. It honours destination almost-full backpressure and enforces a VC0:VC1 service ratio so VC1 is never starved. It is enabled by the top-level FSM's active condition and reports idle back to it.

## Interface
- DATA_SIZE, 6, width of a VC/destination word
- DEST_BIT, 4, bit index of the destination select in a word (0 -> D0, 1 -> D1)
- VC0_WEIGHT, 3, max consecutive VC0 grants while VC1 is also eligible (>=1)
- CNT_SIZE, 8, width of per-VC served counters

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_L  in  1  synchronous, active-high reset (asserted = 1, sampled on clk)
- enable  in  1  FSM active condition; 0 blocks new grants
- vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags
- vc0_data, vc1_data  in  DATA_SIZE each  VC FIFO head word (first-word-fall-through, valid when !empty)
- d0_almost_full, d1_almost_full  in  1 each  destination backpressure
- vc0_pop, vc1_pop  out  1 each  combinational pop, consumes head at this edge
- d0_push, d1_push  out  1 each  registered push strobes
- d_data  out  DATA_SIZE  registered word for D0/D1
- vc0_served, vc1_served  out  CNT_SIZE each  words forwarded per VC, wrapping
- sched_idle  out  1  registered; 1 when no grant this cycle and no push pending

## Operation
- Eligibility: vcN_elig = enable & !vcN_empty & !dK_almost_full, K = vcN_data[DEST_BIT].
- States: IDLE (no eligible VC), RUN (a grant issued this cycle). State register next = RUN if any vcN_elig, else IDLE.
- Weight counter wcnt, 0..VC0_WEIGHT:
  - both eligible, wcnt < VC0_WEIGHT: grant VC0, wcnt+1
  - both eligible, wcnt == VC0_WEIGHT: grant VC1, wcnt=0
  - only VC0 eligible: grant VC0, wcnt saturating +1
  - only VC1 eligible: grant VC1, wcnt=0
  - neither: no grant, wcnt held
- Grant to VCn: vcn_pop=1 same cycle; at the edge d_data <= vcn_data, dK_push <= 1 for K = dest bit, the other push 0; vcn_served +1 (wraps 2^CNT_SIZE-1 -> 0).
- No grant: both pushes 0 next cycle, d_data holds last value.
- At most one pop and one push per cycle; d0_push and d1_push never both 1.
- enable falling: no pop that cycle; a push registered on the previous edge still completes.
- vcN_pop never asserted while vcN_empty=1 (no underflow by construction).

## Timing
- Reset (reset_L=1 at edge): d0_push=d1_push=0, d_data=0, vc0_served=vc1_served=0, wcnt=0, state IDLE, sched_idle=1. Pops are 0 while reset_L=1.
- Pop to push latency: 1 cycle (pop in cycle N, push high in N+1 with the popped word).
- Throughput: 1 word/cycle sustained.
- Backpressure is sampled in the grant cycle; the push lands one cycle later, so destination almost-full thresholds must leave >=1 free slot margin.
- sched_idle(N+1) = !grant(N) & !push pending after edge N, i.e. high one cycle after the last push.
- Reset mid-transfer: the pending push is dropped, counters cleared; the popped word is lost (integrator resets the FIFOs together).

## Test plan
- Reset: assert reset_L 2 cycles with both VCs non-empty -> no pops, all outputs 0, sched_idle=1.
- VC0-only stream: VC0 holds 0x05,0x15,0x25 (bit4: D0,D1,D0) -> pushes d0,d1,d0 in consecutive cycles with those values, each 1 cycle after pop; vc0_served=3.
- Weighting: both VCs full of D0 words, VC0_WEIGHT=3 -> grant sequence 0,0,0,1,0,0,0,1...; after 8 grants vc0_served=6, vc1_served=2.
- Backpressure: VC0 head dest D1, d1_almost_full=1, VC1 head dest D0 -> only VC1 popped; release d1_almost_full -> VC0 popped next cycle.
- Enable drop: deassert enable mid-stream -> no pop that cycle, prior grant still pushes, sched_idle=1 one cycle later.
- Counter wrap: CNT_SIZE=8, 256 VC1 grants -> vc1_served returns to 0.
